// File: rtl/mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch (read-only) and the LSU.
// The LSU has fixed priority, a run counter guards fetch against starvation, and
// every memory transaction is aborted after a bounded wait.
module mem_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MAX_LSU_RUN = 4,
   parameter int unsigned TIMEOUT     = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   // fetch port
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_stall_o,
   // load/store port
   input  logic              lsu_req_i,
   input  logic              lsu_we_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   input  logic [DATA_W-1:0] lsu_wdata_i,
   output logic              lsu_ack_o,
   output logic [DATA_W-1:0] lsu_rdata_o,
   output logic              lsu_stall_o,
   // memory port
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              err_o
);

   typedef enum logic [1:0] {StIdle, StGntIf, StGntLsu, StTurn} state_e;

   localparam logic [3:0] MaxRun = 4'(MAX_LSU_RUN);
   localparam logic [7:0] ToLast = 8'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [3:0]        run_cnt_q, run_cnt_d;
   logic [7:0]        to_cnt_q, to_cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              if_ack_q, if_ack_d;
   logic              lsu_ack_q, lsu_ack_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
   logic              err_q, err_d;
   logic              grant_lsu;
   logic              in_gnt;

   // LSU wins unless fetch is waiting and the LSU has used up its run budget.
   assign grant_lsu = lsu_req_i && (!if_req_i || (run_cnt_q < MaxRun));
   assign in_gnt    = (state_q == StGntIf) || (state_q == StGntLsu);

   always_comb begin
      state_d     = state_q;
      run_cnt_d   = run_cnt_q;
      to_cnt_d    = to_cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_ack_d    = 1'b0;
      lsu_ack_d   = 1'b0;
      if_rdata_d  = '0;
      lsu_rdata_d = '0;
      err_d       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (grant_lsu) begin
               state_d  = StGntLsu;
               addr_d   = lsu_addr_i;
               we_d     = lsu_we_i;
               wdata_d  = lsu_wdata_i;
               to_cnt_d = '0;
               if (!if_req_i) begin
                  run_cnt_d = '0;
               end else if (run_cnt_q != 4'hF) begin
                  run_cnt_d = run_cnt_q + 4'd1;
               end
            end else if (if_req_i) begin
               state_d   = StGntIf;
               addr_d    = if_addr_i;
               we_d      = 1'b0;
               wdata_d   = '0;
               to_cnt_d  = '0;
               run_cnt_d = '0;
            end
         end
         StGntIf, StGntLsu: begin
            if (mem_ack_i) begin
               state_d = StTurn;
               if (state_q == StGntIf) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = mem_rdata_i;
               end else begin
                  lsu_ack_d   = 1'b1;
                  lsu_rdata_d = we_q ? '0 : mem_rdata_i;
               end
            end else if (to_cnt_q == ToLast) begin
               // Abort: ack with zero data so the waiting requester cannot deadlock.
               state_d = StTurn;
               err_d   = 1'b1;
               if (state_q == StGntIf) begin
                  if_ack_d = 1'b1;
               end else begin
                  lsu_ack_d = 1'b1;
               end
            end else begin
               to_cnt_d = to_cnt_q + 8'd1;
            end
         end
         StTurn: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         run_cnt_q   <= '0;
         to_cnt_q    <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_ack_q    <= 1'b0;
         lsu_ack_q   <= 1'b0;
         if_rdata_q  <= '0;
         lsu_rdata_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_cnt_q   <= run_cnt_d;
         to_cnt_q    <= to_cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if_ack_q    <= if_ack_d;
         lsu_ack_q   <= lsu_ack_d;
         if_rdata_q  <= if_rdata_d;
         lsu_rdata_q <= lsu_rdata_d;
         err_q       <= err_d;
      end
   end

   // mem_req_o comes straight from the state register so an async reset drops it at once.
   assign mem_req_o   = in_gnt;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

   assign if_ack_o    = if_ack_q;
   assign if_rdata_o  = if_rdata_q;
   assign lsu_ack_o   = lsu_ack_q;
   assign lsu_rdata_o = lsu_rdata_q;
   assign err_o       = err_q;

   assign if_stall_o  = if_req_i & ~if_ack_q & ~rst_i;
   assign lsu_stall_o = lsu_req_i & ~lsu_ack_q & ~rst_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, collision, starvation guard, timeout,
// async reset mid-transaction and spurious memory ack.
module tb_mem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_ack_o;
   logic [31:0] if_rdata_o;
   logic        if_stall_o;
   logic        lsu_req_i;
   logic        lsu_we_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_wdata_i;
   logic        lsu_ack_o;
   logic [31:0] lsu_rdata_o;
   logic        lsu_stall_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        err_o;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .MAX_LSU_RUN(4),
      .TIMEOUT    (16)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .if_req_i   (if_req_i),
      .if_addr_i  (if_addr_i),
      .if_ack_o   (if_ack_o),
      .if_rdata_o (if_rdata_o),
      .if_stall_o (if_stall_o),
      .lsu_req_i  (lsu_req_i),
      .lsu_we_i   (lsu_we_i),
      .lsu_addr_i (lsu_addr_i),
      .lsu_wdata_i(lsu_wdata_i),
      .lsu_ack_o  (lsu_ack_o),
      .lsu_rdata_o(lsu_rdata_o),
      .lsu_stall_o(lsu_stall_o),
      .mem_req_o  (mem_req_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_ack_i  (mem_ack_i),
      .mem_rdata_i(mem_rdata_i),
      .err_o      (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i       = 1'b1;
      if_req_i    = 1'b1;
      if_addr_i   = '0;
      lsu_req_i   = 1'b0;
      lsu_we_i    = 1'b0;
      lsu_addr_i  = '0;
      lsu_wdata_i = '0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      #1;
      chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
      chk("rst_mem_addr", mem_addr_o, 32'd0);
      chk("rst_if_ack", {31'd0, if_ack_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      chk("rst_if_stall_forced", {31'd0, if_stall_o}, 32'd0);
      if_req_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;

      // Single fetch, memory acks on the second cycle of mem_req_o
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0100;
      tick();
      chk("f1_mem_req", {31'd0, mem_req_o}, 32'd1);
      chk("f1_mem_addr", mem_addr_o, 32'h100);
      chk("f1_mem_we", {31'd0, mem_we_o}, 32'd0);
      chk("f1_if_stall", {31'd0, if_stall_o}, 32'd1);
      tick();
      chk("f1_mem_req_hold", {31'd0, mem_req_o}, 32'd1);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hDEAD_BEEF;
      tick();
      chk("f1_if_ack", {31'd0, if_ack_o}, 32'd1);
      chk("f1_if_rdata", if_rdata_o, 32'hDEAD_BEEF);
      chk("f1_if_stall_low", {31'd0, if_stall_o}, 32'd0);
      chk("f1_turn_no_req", {31'd0, mem_req_o}, 32'd0);
      chk("f1_lsu_ack", {31'd0, lsu_ack_o}, 32'd0);
      mem_ack_i = 1'b0;
      if_req_i  = 1'b0;
      tick();
      chk("f1_ack_once", {31'd0, if_ack_o}, 32'd0);

      // Collision: LSU store wins, fetch follows after turnaround
      if_req_i    = 1'b1;
      if_addr_i   = 32'h0000_0104;
      lsu_req_i   = 1'b1;
      lsu_we_i    = 1'b1;
      lsu_addr_i  = 32'h0000_0200;
      lsu_wdata_i = 32'h1234_5678;
      tick();
      chk("c_mem_addr_lsu", mem_addr_o, 32'h200);
      chk("c_mem_we", {31'd0, mem_we_o}, 32'd1);
      chk("c_mem_wdata", mem_wdata_o, 32'h1234_5678);
      chk("c_lsu_stall", {31'd0, lsu_stall_o}, 32'd1);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hAAAA_5555;
      tick();
      chk("c_lsu_ack", {31'd0, lsu_ack_o}, 32'd1);
      chk("c_store_rdata_zero", lsu_rdata_o, 32'd0);
      chk("c_if_ack_excl", {31'd0, if_ack_o}, 32'd0);
      mem_ack_i = 1'b0;
      lsu_req_i = 1'b0;
      lsu_we_i  = 1'b0;
      tick();
      chk("c_idle_no_req", {31'd0, mem_req_o}, 32'd0);
      tick();
      chk("c_fetch_req", {31'd0, mem_req_o}, 32'd1);
      chk("c_fetch_addr", mem_addr_o, 32'h104);
      chk("c_fetch_we", {31'd0, mem_we_o}, 32'd0);
      chk("c_fetch_wdata", mem_wdata_o, 32'd0);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hCAFE_F00D;
      tick();
      chk("c_if_ack", {31'd0, if_ack_o}, 32'd1);
      chk("c_if_rdata", if_rdata_o, 32'hCAFE_F00D);
      mem_ack_i = 1'b0;
      if_req_i  = 1'b0;
      tick();

      // Starvation guard: four LSU grants, one fetch, then LSU again
      lsu_req_i  = 1'b1;
      lsu_we_i   = 1'b0;
      lsu_addr_i = 32'h0000_0300;
      if_req_i   = 1'b1;
      if_addr_i  = 32'h0000_0108;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("s_mem_req", {31'd0, mem_req_o}, 32'd1);
         chk("s_grant_addr", mem_addr_o, (i == 4) ? 32'h108 : 32'h300);
         mem_ack_i   = 1'b1;
         mem_rdata_i = 32'h10 + 32'(i);
         tick();
         chk("s_if_ack", {31'd0, if_ack_o}, (i == 4) ? 32'd1 : 32'd0);
         chk("s_lsu_ack", {31'd0, lsu_ack_o}, (i == 4) ? 32'd0 : 32'd1);
         mem_ack_i = 1'b0;
         if (i == 4) if_req_i = 1'b0;
         if (i == 5) lsu_req_i = 1'b0;
         tick();
      end

      // Timeout: LSU load never acked
      lsu_req_i   = 1'b1;
      lsu_we_i    = 1'b0;
      lsu_addr_i  = 32'h0000_0400;
      mem_rdata_i = 32'h5A5A_5A5A;
      tick();
      chk("t_mem_req_first", {31'd0, mem_req_o}, 32'd1);
      for (int i = 1; i < 16; i++) begin
         tick();
         chk("t_mem_req_held", {31'd0, mem_req_o}, 32'd1);
         chk("t_no_err_early", {31'd0, err_o}, 32'd0);
      end
      tick();
      chk("t_mem_req_drop", {31'd0, mem_req_o}, 32'd0);
      chk("t_err", {31'd0, err_o}, 32'd1);
      chk("t_lsu_ack", {31'd0, lsu_ack_o}, 32'd1);
      chk("t_lsu_rdata_zero", lsu_rdata_o, 32'd0);
      lsu_req_i = 1'b0;
      tick();
      chk("t_err_pulse", {31'd0, err_o}, 32'd0);

      // Async reset while fetch is granted
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0500;
      tick();
      chk("r_mem_req_before", {31'd0, mem_req_o}, 32'd1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("r_mem_req_drop", {31'd0, mem_req_o}, 32'd0);
      chk("r_if_stall_forced", {31'd0, if_stall_o}, 32'd0);
      tick();
      chk("r_no_if_ack", {31'd0, if_ack_o}, 32'd0);
      rst_i = 1'b0;
      tick();
      chk("r_regrant", {31'd0, mem_req_o}, 32'd1);
      chk("r_regrant_addr", mem_addr_o, 32'h500);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h0000_0055;
      tick();
      chk("r_if_ack", {31'd0, if_ack_o}, 32'd1);
      chk("r_if_rdata", if_rdata_o, 32'h55);
      mem_ack_i = 1'b0;
      if_req_i  = 1'b0;
      tick();

      // Spurious ack in IDLE is ignored
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h0000_0077;
      tick();
      chk("sp_if_ack", {31'd0, if_ack_o}, 32'd0);
      chk("sp_lsu_ack", {31'd0, lsu_ack_o}, 32'd0);
      chk("sp_mem_req", {31'd0, mem_req_o}, 32'd0);
      chk("sp_err", {31'd0, err_o}, 32'd0);
      mem_ack_i = 1'b0;
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0600;
      tick();
      chk("sp_next_grant", {31'd0, mem_req_o}, 32'd1);
      chk("sp_next_addr", mem_addr_o, 32'h600);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h0000_0066;
      tick();
      chk("sp_next_ack", {31'd0, if_ack_o}, 32'd1);
      mem_ack_i = 1'b0;
      if_req_i  = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequencer/arbiter that shares one single-port unified memory between the instruction fetch path (read-only) and the LSU (read/write).
- Sits between the datapath requesters and the memory, one instance per core.
- Drives the per-requester stall signals that freeze the PC/pipeline while a requester waits.
- Fixed priority to LSU, a starvation guard for fetch, and a per-transaction timeout.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
MAX_LSU_RUN, 4, max consecutive LSU grants while fetch is pending before fetch is forced (1..15)
TIMEOUT, 16, cycles to wait for mem_ack_i before aborting (2..255)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  asynchronous reset, active-high
if_req_i  in  1  fetch read request; held until if_ack_o
if_addr_i  in  ADDR_W  fetch address
if_ack_o  out  1  one-cycle pulse: fetch done, if_rdata_o valid
if_rdata_o  out  DATA_W  fetch read data
if_stall_o  out  1  fetch pending and not yet acked
lsu_req_i  in  1  LSU request; held until lsu_ack_o
lsu_we_i  in  1  1 = store, 0 = load
lsu_addr_i  in  ADDR_W  LSU address
lsu_wdata_i  in  DATA_W  store data
lsu_ack_o  out  1  one-cycle pulse: LSU transaction done
lsu_rdata_o  out  DATA_W  load data, valid with lsu_ack_o
lsu_stall_o  out  1  LSU pending and not yet acked
mem_req_o  out  1  memory request, held until mem_ack_i or abort
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_ack_i  in  1  memory completion, one cycle; mem_rdata_i valid same cycle
mem_rdata_i  in  DATA_W  memory read data
err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst_i high, async):
  - State IDLE; run and timeout counters 0.
  - All outputs 0: acks, rdata, err, mem_req/we/addr/wdata.
  - Stall outputs follow their combinational equations and are forced 0 while rst_i is high.
- Reset asserted mid-transaction: the transaction is dropped with no ack; mem_req_o drops immediately.
- States: IDLE, GNT_IF, GNT_LSU, TURN.
- IDLE arbitration:
  - lsu_req_i and (if_req_i = 0 or run_cnt < MAX_LSU_RUN): go to GNT_LSU.
  - Else if if_req_i: go to GNT_IF.
  - Else stay in IDLE.
- On entry to a GNT state:
  - Latch addr, we, wdata into mem_* registers (fetch: we = 0, wdata = 0).
  - mem_req_o = 1 starting the cycle after the IDLE decision.
  - Timeout counter cleared.
- In GNT state, mem_ack_i = 1:
  - The matching requester gets ack = 1 and rdata = mem_rdata_i (registered, next cycle); stores also pulse ack, rdata = 0.
  - mem_req_o = 0; go to TURN.
- In GNT state, no ack: timeout counter increments. When it reaches TIMEOUT-1 without ack:
  - Abort: mem_req_o = 0, err_o pulses one cycle.
  - Requester ack pulses with rdata = 0, so the core never deadlocks; go to TURN.
- TURN: one mandatory turnaround cycle, no mem_req_o; go to IDLE.
  - Minimum transaction = 3 cycles from req to next possible grant.
- run_cnt (4 bits, saturating):
  - +1 on each LSU grant while if_req_i = 1.
  - Cleared on any fetch grant, and on an LSU grant with if_req_i = 0.
- Stalls (combinational):
  - if_stall_o = if_req_i & ~if_ack_o.
  - lsu_stall_o = lsu_req_i & ~lsu_ack_o.
- mem_ack_i outside GNT states is ignored. Requests changing while granted are ignored (latched copy used).
- Acks are exclusive: never both in the same cycle.

Test Plan:
- Single fetch: if_req_i = 1 with addr 0x0000_0100, memory acks 2 cycles after mem_req_o with rdata 0xDEAD_BEEF -> mem_addr_o = 0x100, mem_we_o = 0; if_ack_o pulses once with if_rdata_o = 0xDEAD_BEEF; if_stall_o low the same cycle.
- Collision: if_req_i and lsu_req_i rise together, LSU store 0x0000_0200 <- 0x1234_5678 -> LSU granted first with mem_we_o = 1 and mem_wdata_o = 0x1234_5678; after TURN, fetch granted.
- Starvation guard: lsu_req_i held high continuously with fetch pending, MAX_LSU_RUN = 4 -> exactly 4 LSU grants, then 1 fetch grant, then LSU resumes.
- Timeout: LSU load, memory never acks, TIMEOUT = 16 -> mem_req_o drops after 16 cycles; err_o and lsu_ack_o pulse together with lsu_rdata_o = 0.
- Async reset mid-transaction: rst_i pulsed while GNT_IF is active -> mem_req_o = 0 immediately, no if_ack_o; after release, a held if_req_i is re-granted from IDLE.
- Spurious ack: mem_ack_i pulsed in IDLE -> no if_ack_o or lsu_ack_o, state unchanged.
